// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: funct3 op codes,
// FSM states and the divide special-case constants.
package ex_muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [MD_XLEN-1:0] MD_DIV0_Q       = '1;
  localparam logic [MD_XLEN-1:0] MD_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic md_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_serial_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder
// and keep the subtraction only when it does not borrow.
module serial_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < div_i always holds, so diff[XLEN] is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (IDLE/CALC/DONE). Defining
// MULDIV_FAST_MUL_EN makes the four multiplies single-cycle combinational.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE) and
  // flush=0; valid pulses for one cycle and result is held until the next pulse.
  md_state_e         state_q;
  md_op_e            op_q;
  md_op_e            op_in;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              rneg_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  logic              is_div, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  md_state_e         l_state;
  logic [2*XLEN-1:0] l_acc;
  logic [XLEN-1:0]   l_opb;
  logic              l_neg, l_rneg;

  assign op_in = md_op_e'(op);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  assign fast_prod = $signed({md_a_signed(op_in) & src_a[XLEN-1], src_a})
                   * $signed({md_b_signed(op_in) & src_b[XLEN-1], src_b});
`endif

  // Launch values: the accumulator holds {remainder, quotient} for divides and
  // {product_hi, multiplier} for multiplies; specials preload the final answer.
  always_comb begin
    is_div   = op[2];
    sa       = md_a_signed(op_in) & src_a[XLEN-1];
    sb       = md_b_signed(op_in) & src_b[XLEN-1];
    mag_a    = sa ? -src_a : src_a;
    mag_b    = sb ? -src_b : src_b;
    div_zero = is_div && (src_b == '0);
    div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
               (src_a == MD_OVF_DIVIDEND) && (src_b == '1);
    l_state  = MD_CALC;
    l_acc    = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
    l_opb    = is_div ? mag_b : mag_a;
    l_neg    = sa ^ sb;
    l_rneg   = sa;
    if (div_zero) begin
      l_state = MD_DONE;
      l_acc   = {src_a, MD_DIV0_Q};
      l_neg   = 1'b0;
      l_rneg  = 1'b0;
    end else if (div_ovf) begin
      l_state = MD_DONE;
      l_acc   = {{XLEN{1'b0}}, MD_OVF_DIVIDEND};
      l_neg   = 1'b0;
      l_rneg  = 1'b0;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      l_state = MD_DONE;
      l_acc   = fast_prod[2*XLEN-1:0];
      l_neg   = 1'b0;
      l_rneg  = 1'b0;
    end
`endif
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0]   div_rem, div_quo;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  serial_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (opb_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, done_res;

  always_comb begin
    prod     = neg_q  ? -acc_q : acc_q;
    quo      = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    done_res = rem;
    case (op_q)
      MD_MUL:                       done_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: done_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              done_res = quo;
      default:                      done_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        MD_CALC: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else begin
            acc_q <= is_div_q() ? {div_rem, div_quo} : mul_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else begin
            result_q <= done_res;
            valid_q  <= 1'b1;
            state_q  <= MD_IDLE;
            if (start) begin
              state_q <= l_state;
              op_q    <= op_in;
              acc_q   <= l_acc;
              opb_q   <= l_opb;
              neg_q   <= l_neg;
              rneg_q  <= l_rneg;
              cnt_q   <= CNT_W'(XLEN-1);
            end
          end
        end
        default: begin
          if (start && !flush) begin
            state_q <= l_state;
            op_q    <= op_in;
            acc_q   <= l_acc;
            opb_q   <= l_opb;
            neg_q   <= l_neg;
            rneg_q  <= l_rneg;
            cnt_q   <= CNT_W'(XLEN-1);
          end
        end
      endcase
    end
  end

  function automatic logic is_div_q();
    return op_q[2];
  endfunction

  assign busy   = (state_q == MD_CALC);
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: a driver pushes reference results and
// completion cycles, a negedge monitor pops them whenever valid pulses.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, valid;
  logic [31:0] result;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_exp = 32'd0;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t dir[12] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         32'd14},
    '{3'd7, 32'd100,        32'd7,         32'd2},
    '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,         32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // reference model: plain RV32M arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 ia, ib;
    ia = a;
    ib = b;
    case (o)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = 64'(signed'(ia)) * 64'(signed'(ib)); return sp[63:32]; end
      3'd2: begin sp = 64'(signed'(ia)) * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 33;
  endfunction

  // driver: expects to be called just after a rising edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input bit track);
    int t = 0;
    int e0;
    while (busy && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) check("issue_wait_timeout", {31'd0, busy}, 32'd0);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    if (track) begin
      exp_q.push_back(exp_r);
      exp_cyc_q.push_back(e0 + latency(o, a, b));
      last_exp = exp_r;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        logic [31:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", result, e);
        check("latency_edge", cyc, ec);
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    int          nb;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk);
    #1;

    // directed vectors; the first also checks the busy window
    issue(dir[0].o, dir[0].a, dir[0].b, dir[0].r, 1'b1);
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) nb++;
    end
`ifdef MULDIV_FAST_MUL_EN
    check("busy_cycles", nb, 32'd0);
`else
    check("busy_cycles", nb, 32'd32);
`endif
    @(posedge clk);
    #1;
    for (int i = 1; i < 12; i++) issue(dir[i].o, dir[i].a, dir[i].b, dir[i].r, 1'b1);
    drain();

    // randomized, issued back-to-back so many starts land in the DONE cycle
    repeat (60) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_opnd();
      rb = rand_opnd();
      issue(ro, ra, rb, ref_model(ro, ra, rb), 1'b1);
    end
    drain();

    // flush during CALC at cycle 10
    issue(3'd4, 32'd1000, 32'd7, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_busy", {31'd0, busy}, 32'd0);
    check("flush_calc_result", result, last_exp);
    repeat (40) @(posedge clk);
    #1;

    // flush during DONE
    issue(3'd5, 32'd999, 32'd10, 32'd0, 1'b0);
    nb = 0;
    while (busy && nb < 100) begin
      @(posedge clk);
      #1;
      nb++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_done_result", result, last_exp);

    // flush beats start in IDLE
    op = 3'd0;
    src_a = 32'd3;
    src_b = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_idle_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // asynchronous reset mid-divide
    issue(3'd4, 32'hFFFF_0000, 32'd3, 32'd0, 1'b0);
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_valid", {31'd0, valid}, 32'd0);
    check("async_rst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_exp = 32'd0;
    issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
